// File: rtl/distributed_ram_queue.sv
// Circular FIFO over a 1-write/1-async-read distributed RAM. Occupancy is tracked
// in a dedicated count register, so full/empty never depend on pointer equality.
module distributed_ram_queue #(
  parameter int ENTRY_NUM      = 4,
  parameter int ENTRY_BIT_SIZE = 4,
  parameter int INDEX_BIT_SIZE = $clog2(ENTRY_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              pushValid,
  output logic                              pushReady,
  input  logic [ENTRY_BIT_SIZE-1:0]         pushData,
  output logic                              popValid,
  input  logic                              popReady,
  output logic [ENTRY_BIT_SIZE-1:0]         popData,
  output logic [$clog2(ENTRY_NUM+1)-1:0]    count,
  output logic                              full,
  output logic                              empty
);

  localparam int COUNT_BIT_SIZE = $clog2(ENTRY_NUM + 1);

  logic [ENTRY_BIT_SIZE-1:0] mem [ENTRY_NUM];
  logic [INDEX_BIT_SIZE-1:0] head_ptr;
  logic [INDEX_BIT_SIZE-1:0] tail_ptr;
  logic [COUNT_BIT_SIZE-1:0] count_q;
  logic                      push_fire;
  logic                      pop_fire;

  // Status comes from registers only; no path from pushValid/popReady.
  assign full      = (count_q == COUNT_BIT_SIZE'(ENTRY_NUM));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pushReady = !full;
  assign popValid  = !empty;
  assign popData   = mem[head_ptr];

  // A flush swallows any push offered in the same cycle, including its RAM write.
  assign push_fire = pushValid && pushReady && !flush;
  assign pop_fire  = popValid && popReady && !flush;

  // NOTE: storage has no reset so it maps onto distributed RAM; nothing reads a
  // slot before it has been written because popValid gates popData.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[tail_ptr] <= pushData;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push_fire) begin
        tail_ptr <= tail_ptr + INDEX_BIT_SIZE'(1);
      end
      if (pop_fire) begin
        head_ptr <= head_ptr + INDEX_BIT_SIZE'(1);
      end
      if (push_fire && !pop_fire) begin
        count_q <= count_q + COUNT_BIT_SIZE'(1);
      end else if (pop_fire && !push_fire) begin
        count_q <= count_q - COUNT_BIT_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_distributed_ram_queue.sv
// Directed bench for distributed_ram_queue: a table of per-cycle vectors checked
// just after the driving edge, plus hand-written reset sequences.
module tb_distributed_ram_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [3:0] push_data = '0;
  logic       pop_valid;
  logic       pop_ready = 1'b0;
  logic [3:0] pop_data;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  distributed_ram_queue #(.ENTRY_NUM(4), .ENTRY_BIT_SIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .pushValid (push_valid),
    .pushReady (push_ready),
    .pushData  (push_data),
    .popValid  (pop_valid),
    .popReady  (pop_ready),
    .popData   (pop_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push_valid;
    logic [3:0] push_data;
    logic       pop_ready;
    logic       flush;
    int         exp_count;  // occupancy before this cycle's edge
    logic [3:0] exp_data;   // head entry, checked only when non-empty
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic pv, logic [3:0] pd, logic pr, logic fl,
                             int ec, logic [3:0] ed);
    vec_t r;
    r.push_valid = pv; r.push_data = pd; r.pop_ready = pr; r.flush = fl;
    r.exp_count = ec; r.exp_data = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input int ec, input logic [3:0] ed);
    check({tag, " count"}, 32'(count), 32'(ec));
    check({tag, " empty"}, 32'(empty), 32'(ec == 0));
    check({tag, " full"}, 32'(full), 32'(ec == 4));
    check({tag, " pushReady"}, 32'(push_ready), 32'(ec != 4));
    check({tag, " popValid"}, 32'(pop_valid), 32'(ec != 0));
    if (ec != 0) check({tag, " popData"}, 32'(pop_data), 32'(ed));
  endtask

  task automatic drive(input logic pv, input logic [3:0] pd, input logic pr, input logic fl);
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
  endtask

  initial begin
    // ---- table: push_valid, push_data, pop_ready, flush, exp_count, exp_data
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 4'h0)); // idle after reset
    vecs.push_back(v(1, 4'h3, 0, 0, 0, 4'h0)); // push 3, no bypass
    vecs.push_back(v(0, 4'h0, 0, 0, 1, 4'h3)); // visible one cycle later
    vecs.push_back(v(0, 4'h0, 1, 0, 1, 4'h3)); // pop
    vecs.push_back(v(0, 4'h0, 1, 0, 0, 4'h0)); // empty, popReady ignored
    vecs.push_back(v(1, 4'h1, 0, 0, 0, 4'h0)); // fill 1..4
    vecs.push_back(v(1, 4'h2, 0, 0, 1, 4'h1));
    vecs.push_back(v(1, 4'h3, 0, 0, 2, 4'h1));
    vecs.push_back(v(1, 4'h4, 0, 0, 3, 4'h1));
    vecs.push_back(v(1, 4'h9, 0, 0, 4, 4'h1)); // push while full: ignored
    vecs.push_back(v(0, 4'h0, 0, 0, 4, 4'h1));
    vecs.push_back(v(0, 4'h0, 1, 0, 4, 4'h1)); // pop 1
    vecs.push_back(v(0, 4'h0, 1, 0, 3, 4'h2)); // pop 2
    vecs.push_back(v(1, 4'h5, 0, 0, 2, 4'h3)); // push 5 (tail wraps)
    vecs.push_back(v(1, 4'h6, 0, 0, 3, 4'h3)); // push 6
    vecs.push_back(v(0, 4'h0, 1, 0, 4, 4'h3)); // pops across the wrap
    vecs.push_back(v(0, 4'h0, 1, 0, 3, 4'h4));
    vecs.push_back(v(0, 4'h0, 1, 0, 2, 4'h5));
    vecs.push_back(v(1, 4'hc, 1, 0, 1, 4'h6)); // holds {6}: push c + pop
    vecs.push_back(v(1, 4'h7, 0, 0, 1, 4'hc)); // c next, count held
    vecs.push_back(v(1, 4'h8, 0, 0, 2, 4'hc));
    vecs.push_back(v(1, 4'hb, 0, 0, 3, 4'hc));
    vecs.push_back(v(1, 4'hf, 1, 0, 4, 4'hc)); // full: pop + push f, push refused
    vecs.push_back(v(0, 4'h0, 0, 0, 3, 4'h7));
    vecs.push_back(v(0, 4'h0, 1, 0, 3, 4'h7));
    vecs.push_back(v(0, 4'h0, 1, 0, 2, 4'h8));
    vecs.push_back(v(0, 4'h0, 1, 0, 1, 4'hb));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 4'h0)); // f never appeared
    vecs.push_back(v(1, 4'h2, 0, 0, 0, 4'h0)); // build count 3
    vecs.push_back(v(1, 4'h4, 0, 0, 1, 4'h2));
    vecs.push_back(v(1, 4'h6, 0, 0, 2, 4'h2));
    vecs.push_back(v(1, 4'ha, 0, 1, 3, 4'h2)); // flush with push a
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 4'h0));
    vecs.push_back(v(1, 4'h1, 0, 0, 0, 4'h0));
    vecs.push_back(v(0, 4'h0, 1, 0, 1, 4'h1));
    vecs.push_back(v(0, 4'h0, 0, 0, 0, 4'h0));

    // ---- asynchronous reset mid-cycle, no clock edge needed
    #3 rst_n = 1'b0;
    #1 check_status("reset", 0, 4'h0);
    @(negedge clk) rst_n = 1'b1;

    // ---- table-driven section: drive on negedge, check before next posedge
    foreach (vecs[i]) begin
      drive(vecs[i].push_valid, vecs[i].push_data, vecs[i].pop_ready, vecs[i].flush);
      #1 check_status($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_data);
      @(negedge clk);
    end

    // ---- async reset between edges with count 3, then reuse
    drive(1, 4'h2, 0, 0); @(negedge clk);
    drive(1, 4'h4, 0, 0); @(negedge clk);
    drive(1, 4'h6, 0, 0); @(negedge clk);
    drive(1, 4'ha, 0, 0);
    #1 check_status("pre_rst", 3, 4'h2);
    #1 rst_n = 1'b0;
    #1 check_status("mid_rst", 0, 4'h0);
    @(posedge clk);
    #1 check_status("rst_held", 0, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 4'h1, 0, 0);
    #1 check_status("post_rst_push", 0, 4'h0);
    @(negedge clk) drive(0, 4'h0, 1, 0);
    #1 check_status("post_rst_pop", 1, 4'h1);
    @(negedge clk) drive(0, 4'h0, 0, 0);
    #1 check_status("post_rst_empty", 0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/distributed_ram_queue.md
# distributed_ram_queue

Circular FIFO built on a 1-write/1-async-read distributed dual-port RAM, acting as the reader end of that RAM. A producer pushes entries through a valid/ready write port. The block owns the write and read pointers and streams entries out in order through a valid/ready read port. It is the standard queue primitive for small in-order buffers in the pipeline.

## Interface
Parameters:
- ENTRY_NUM, 4, queue depth; power of two, ≥ 2
- ENTRY_BIT_SIZE, 4, data width per entry
- INDEX_BIT_SIZE, $clog2(ENTRY_NUM), pointer width (derived)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of queue contents
- pushValid  in  1  producer offers pushData this cycle
- pushReady  out  1  queue can accept an entry (= !full)
- pushData  in  ENTRY_BIT_SIZE  entry to enqueue
- popValid  out  1  popData holds the oldest entry (= !empty)
- popReady  in  1  consumer takes popData this cycle
- popData  out  ENTRY_BIT_SIZE  RAM[headPtr], asynchronous read
- count  out  $clog2(ENTRY_NUM+1)  number of valid entries
- full  out  1  count == ENTRY_NUM
- empty  out  1  count == 0

## Operation
- State: headPtr, tailPtr (INDEX_BIT_SIZE each), count register; storage in the distributed RAM. RAM contents are not reset.
- Push fires when pushValid && pushReady:
  - RAM[tailPtr] <= pushData
  - tailPtr increments modulo ENTRY_NUM (natural wrap)
- Pop fires when popValid && popReady: headPtr increments modulo ENTRY_NUM.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- popData = RAM[headPtr], combinational through the RAM read port. Valid only while popValid = 1; otherwise don't-care.
- Full or empty is derived from count, never from pointer equality alone.
- Boundary rules:
  - Empty + push: no bypass. Entry becomes visible on popValid/popData the cycle after the push edge.
  - Full: pushReady = 0. A push offered while full is ignored, even if a pop fires in the same cycle.
  - Empty: popValid = 0. popReady is ignored.
  - Simultaneous push and pop with 0 < count < ENTRY_NUM: both fire, count holds, both pointers advance.
  - Push to the slot being read in the same cycle (possible only when count == ENTRY_NUM - ... never, since head ≠ tail when 0 < count < ENTRY_NUM): no read/write hazard.
- flush (synchronous, priority over push/pop):
  - headPtr, tailPtr and count go to 0.
  - A push in the flush cycle is discarded (no RAM write).
- Reset (asynchronous assertion, mid-operation included):
  - headPtr, tailPtr and count go to 0 immediately.
  - Outputs go to reset values without waiting for clk.
  - Deassertion is assumed synchronized externally.

## Timing
- Reset values:
  - pushReady = 1, popValid = 0, count = 0, full = 0, empty = 1
  - popData don't-care
- Write-to-read latency: 1 cycle (push at edge N, poppable from N+1).
- Pop-to-next-entry latency: 0 cycles. After the pop edge, popData shows the next entry combinationally.
- Throughput: 1 push + 1 pop per cycle sustained when neither full nor empty.
- pushReady, popValid, full, empty and count are functions of registers only (no combinational path from pushValid/popReady). popData depends combinationally on headPtr and RAM only.

## Test plan
Bench uses ENTRY_NUM = 4, ENTRY_BIT_SIZE = 4.
- Reset then idle: rst_n low mid-cycle -> immediately pushReady = 1, popValid = 0, count = 0, empty = 1, full = 0.
- Single entry: push 4'h3 -> next cycle popValid = 1, popData = 4'h3, count = 1. Pop -> following cycle empty = 1.
- Fill and wrap:
  - push 1, 2, 3, 4 -> full = 1, pushReady = 0.
  - Push 4'h9 while full -> ignored, count stays 4.
  - Pop 2 (popData 1 then 2), push 5, 6 -> pops return 3, 4, 5, 6 in order across the pointer wrap.
- Simultaneous push/pop:
  - Queue holds {4'h6}.
  - push 4'hc with pop in the same cycle -> popData = 4'h6 that cycle, 4'hc the next, count stays 1.
- Full + pop + push offered: count 4, pop and push 4'hf in the same cycle -> push refused, count = 3, 4'hf never appears.
- Flush and async reset mid-stream:
  - count 3, flush with push 4'ha -> next cycle count = 0, empty = 1, and a subsequent push 4'h1 pops as 4'h1.
  - Repeat with rst_n asserted between edges -> identical cleared state.
